// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback path.
package wb_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam logic [4:0]  REG_ZERO     = 5'd0;

  typedef struct packed {
    logic [4:0]              rd;
    logic [XLEN_DEFAULT-1:0] data;
  } wb_entry_t;

  // Register zero is hardwired, so writes to it never count as requests.
  function automatic logic is_real_rd(input logic [4:0] rd);
    return rd != REG_ZERO;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending load writebacks; exposes every slot for hazard compares.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = wb_entry_t
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  entry_t                     push_entry,
  input  logic                       pop,
  output entry_t                     head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output entry_t                     entries [DEPTH],
  output logic [DEPTH-1:0]           valid
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  entry_t            mem_q [DEPTH];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic [DEPTH-1:0]  valid_q, valid_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    valid_d = valid_q;
    if (pop)  valid_d[rptr_q] = 1'b0;
    if (push) valid_d[wptr_q] = 1'b1;
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (push) wptr_q <= ptr_inc(wptr_q);
      if (pop)  rptr_q <= ptr_inc(rptr_q);
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload storage carries no reset; the valid bits qualify every slot.
  always_ff @(posedge clock) begin
    if (!reset && push) mem_q[wptr_q] <= push_entry;
  end

  assign head    = mem_q[rptr_q];
  assign count   = count_q;
  assign valid   = valid_q;
  assign entries = mem_q;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback arbiter: ALU first, then buffered loads, then load bypass; plus hazard flags.
module regfile_wb_ctrl
  import wb_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       alu_valid,
  input  logic [4:0]                 alu_rd,
  input  logic [XLEN-1:0]            alu_data,
  input  logic                       lsu_valid,
  output logic                       lsu_ready,
  input  logic [4:0]                 lsu_rd,
  input  logic [XLEN-1:0]            lsu_data,
  output logic                       reg_wr,
  output logic [4:0]                 waddr,
  output logic [XLEN-1:0]            wdata,
  input  logic [4:0]                 chk_addr1,
  input  logic [4:0]                 chk_addr2,
  output logic                       pend1,
  output logic                       pend2,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } entry_t;

  logic            eff_alu, lsu_fire, eff_lsu, fifo_empty;
  logic            do_pop, do_push, do_bypass, do_write;
  logic [CntW-1:0] fifo_count;
  entry_t          fifo_head, push_entry, win_entry;
  entry_t          fifo_entries [DEPTH];
  logic [DEPTH-1:0] fifo_valid;

  logic            reg_wr_q;
  logic [4:0]      waddr_q;
  logic [XLEN-1:0] wdata_q;

  // Ready looks only at registered occupancy so it never waits on the ALU.
  assign lsu_ready  = !reset && (fifo_count < CntW'(DEPTH));
  assign lsu_fire   = lsu_valid && lsu_ready;
  assign eff_alu    = alu_valid && is_real_rd(alu_rd);
  assign eff_lsu    = lsu_fire && is_real_rd(lsu_rd);
  assign fifo_empty = (fifo_count == '0);

  assign do_pop    = !eff_alu && !fifo_empty;
  assign do_bypass = !eff_alu && fifo_empty && eff_lsu;
  assign do_push   = eff_lsu && !do_bypass;
  assign do_write  = eff_alu || do_pop || do_bypass;

  assign push_entry = '{rd: lsu_rd, data: lsu_data};

  always_comb begin
    win_entry = push_entry;
    if (eff_alu) begin
      win_entry = '{rd: alu_rd, data: alu_data};
    end else if (do_pop) begin
      win_entry = fifo_head;
    end
  end

  wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (do_push),
    .push_entry (push_entry),
    .pop        (do_pop),
    .head       (fifo_head),
    .count      (fifo_count),
    .entries    (fifo_entries),
    .valid      (fifo_valid)
  );

  // Address and data hold their last value on idle cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      reg_wr_q <= 1'b0;
      waddr_q  <= REG_ZERO;
      wdata_q  <= '0;
    end else begin
      reg_wr_q <= do_write;
      if (do_write) begin
        waddr_q <= win_entry.rd;
        wdata_q <= win_entry.data;
      end
    end
  end

  assign reg_wr = reg_wr_q;
  assign waddr  = waddr_q;
  assign wdata  = wdata_q;
  assign count  = fifo_count;

  always_comb begin
    logic hit1, hit2;
    hit1 = reg_wr_q && (waddr_q == chk_addr1);
    hit2 = reg_wr_q && (waddr_q == chk_addr2);
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (fifo_valid[i] && (fifo_entries[i].rd == chk_addr1)) hit1 = 1'b1;
      if (fifo_valid[i] && (fifo_entries[i].rd == chk_addr2)) hit2 = 1'b1;
    end
    pend1 = is_real_rd(chk_addr1) && hit1;
    pend2 = is_real_rd(chk_addr2) && hit2;
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed vector bench for regfile_wb_ctrl with DEPTH=2, XLEN=32.
module tb_regfile_wb_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid, lsu_valid, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd, waddr, chk_addr1, chk_addr2;
  logic [31:0] alu_data, lsu_data, wdata;
  logic        reg_wr, pend1, pend2;
  logic [1:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  regfile_wb_ctrl #(
    .XLEN  (32),
    .DEPTH (2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .reg_wr    (reg_wr),
    .waddr     (waddr),
    .wdata     (wdata),
    .chk_addr1 (chk_addr1),
    .chk_addr2 (chk_addr2),
    .pend1     (pend1),
    .pend2     (pend2),
    .count     (count)
  );

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic [4:0]  c1;
    logic [4:0]  c2;
    logic        e_rdy;  // before the edge
    logic        e_p1;
    logic        e_p2;
    logic        e_wr;   // after the edge
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic [4:0] c1, input logic [4:0] c2);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    chk_addr1 = c1; chk_addr2 = c2;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_post(input string tag, input logic wr, input logic [4:0] wa,
                            input logic [31:0] wd, input logic [1:0] cnt);
    check({tag, " reg_wr"}, 32'(reg_wr), 32'(wr));
    check({tag, " waddr"},  32'(waddr),  32'(wa));
    check({tag, " wdata"},  wdata,       wd);
    check({tag, " count"},  32'(count),  32'(cnt));
  endtask

  initial begin
    //          av   ard    ad            lv   lrd    ld            c1     c2     rdy  p1   p2   wr   wa     wd            cnt
    vecs[0]  = '{1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'hA5A5A5A5, 2'd0};
    vecs[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 32'hA5A5A5A5, 2'd0};
    vecs[2]  = '{1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 5'd4, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'h11, 2'd1};
    vecs[3]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 32'h22, 2'd0};
    vecs[4]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hDEAD, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 5'd4, 32'h22, 2'd0};
    vecs[5]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'h10, 5'd10, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd10, 32'h10, 2'd0};
    vecs[6]  = '{1'b1, 5'd1, 32'h100, 1'b1, 5'd9, 32'h99, 5'd10, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 32'h100, 2'd1};
    vecs[7]  = '{1'b1, 5'd0, 32'h555, 1'b0, 5'd0, 32'h0, 5'd9, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 32'h99, 2'd0};
    vecs[8]  = '{1'b1, 5'd2, 32'h200, 1'b1, 5'd12, 32'h12, 5'd9, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 32'h200, 2'd1};
    vecs[9]  = '{1'b1, 5'd2, 32'h201, 1'b0, 5'd0, 32'h0, 5'd0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 32'h201, 2'd1};
    vecs[10] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 32'h13, 5'd12, 5'd13, 1'b1, 1'b1, 1'b0, 1'b1, 5'd12, 32'h12, 2'd1};
    vecs[11] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd13, 5'd12, 1'b1, 1'b1, 1'b1, 1'b1, 5'd13, 32'h13, 2'd0};
    vecs[12] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd13, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd13, 32'h13, 2'd0};

    reset = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    tick();
    tick();
    check("reset lsu_ready", 32'(lsu_ready), 32'd0);
    check_post("reset", 1'b0, 5'd0, 32'h0, 2'd0);
    reset = 1'b0;
    #1;
    check("post-reset lsu_ready", 32'(lsu_ready), 32'd1);

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].lv, vecs[i].lrd, vecs[i].ld,
            vecs[i].c1, vecs[i].c2);
      check($sformatf("vec%0d lsu_ready", i), 32'(lsu_ready), 32'(vecs[i].e_rdy));
      check($sformatf("vec%0d pend1", i), 32'(pend1), 32'(vecs[i].e_p1));
      check($sformatf("vec%0d pend2", i), 32'(pend2), 32'(vecs[i].e_p2));
      tick();
      check_post($sformatf("vec%0d", i), vecs[i].e_wr, vecs[i].e_wa, vecs[i].e_wd, vecs[i].e_cnt);
    end

    // Backpressure: ALU to r1 for four cycles while loads r6, r7, r8 queue up.
    drive(1'b1, 5'd1, 32'hA0, 1'b1, 5'd6, 32'h66, 5'd6, 5'd7);
    check("bp0 lsu_ready", 32'(lsu_ready), 32'd1);
    tick();
    check_post("bp0", 1'b1, 5'd1, 32'hA0, 2'd1);
    drive(1'b1, 5'd1, 32'hA1, 1'b1, 5'd7, 32'h77, 5'd6, 5'd7);
    check("bp1 lsu_ready", 32'(lsu_ready), 32'd1);
    tick();
    check_post("bp1", 1'b1, 5'd1, 32'hA1, 2'd2);
    drive(1'b1, 5'd1, 32'hA2, 1'b1, 5'd8, 32'h88, 5'd6, 5'd7);
    check("bp2 lsu_ready", 32'(lsu_ready), 32'd0);
    check("bp2 pend1", 32'(pend1), 32'd1);
    check("bp2 pend2", 32'(pend2), 32'd1);
    tick();
    check_post("bp2", 1'b1, 5'd1, 32'hA2, 2'd2);
    drive(1'b1, 5'd1, 32'hA3, 1'b1, 5'd8, 32'h88, 5'd8, 5'd7);
    check("bp3 lsu_ready", 32'(lsu_ready), 32'd0);
    check("bp3 pend1", 32'(pend1), 32'd0);
    tick();
    check_post("bp3", 1'b1, 5'd1, 32'hA3, 2'd2);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h88, 5'd8, 5'd7);
    check("bp4 lsu_ready", 32'(lsu_ready), 32'd0);
    tick();
    check_post("bp4", 1'b1, 5'd6, 32'h66, 2'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h88, 5'd8, 5'd7);
    check("bp5 lsu_ready", 32'(lsu_ready), 32'd1);
    tick();
    check_post("bp5", 1'b1, 5'd7, 32'h77, 2'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd8, 5'd0);
    check("bp6 pend1", 32'(pend1), 32'd1);
    tick();
    check_post("bp6", 1'b1, 5'd8, 32'h88, 2'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    tick();
    check_post("bp7", 1'b0, 5'd8, 32'h88, 2'd0);

    // Reset mid-operation with two buffered loads and a live ALU request.
    drive(1'b1, 5'd1, 32'hB0, 1'b1, 5'd20, 32'h20, 5'd20, 5'd21);
    tick();
    drive(1'b1, 5'd1, 32'hB1, 1'b1, 5'd21, 32'h21, 5'd20, 5'd21);
    tick();
    check("rst pre count", 32'(count), 32'd2);
    check("rst pre pend2", 32'(pend2), 32'd1);
    reset = 1'b1;
    drive(1'b1, 5'd2, 32'hB2, 1'b1, 5'd22, 32'h22, 5'd20, 5'd21);
    check("rst lsu_ready", 32'(lsu_ready), 32'd0);
    tick();
    check_post("rst", 1'b0, 5'd0, 32'h0, 2'd0);
    check("rst pend1", 32'(pend1), 32'd0);
    check("rst pend2", 32'(pend2), 32'd0);
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd20, 5'd21);
    check("after rst lsu_ready", 32'(lsu_ready), 32'd1);
    tick();
    check_post("after rst", 1'b0, 5'd0, 32'h0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
